// File: rtl/dcpu_irq_unit_if.sv
// dcpu_irq_unit_if: core-side bundle between the dcpu16 CPU state machine and
// the interrupt unit.
//   sw_valid/sw_msg/sw_ready : software INT request into the queue
//   cpu_*                    : core state sampled by the unit (boundary, IAQ, IA, PC, SP, A)
//   ent_*                    : interrupt-entry handoff back to the core
//   ram_*                    : stack writes on the shared RAM port while ent_busy
// Modports: master = core side, slave = interrupt unit.
interface dcpu_irq_unit_if #(
  parameter int unsigned MSG_W = 16
);
  logic             sw_valid;
  logic [MSG_W-1:0] sw_msg;
  logic             sw_ready;

  logic             cpu_boundary;
  logic             cpu_iaq;
  logic [MSG_W-1:0] cpu_ia;
  logic [MSG_W-1:0] cpu_pc;
  logic [MSG_W-1:0] cpu_sp;
  logic [MSG_W-1:0] cpu_a;

  logic             ent_busy;
  logic             ent_done;
  logic [MSG_W-1:0] ent_pc;
  logic [MSG_W-1:0] ent_sp;
  logic [MSG_W-1:0] ent_a;

  logic [15:0]      ram_addr;
  logic [MSG_W-1:0] ram_data;
  logic             ram_wr;

  modport master (
    output sw_valid, sw_msg, cpu_boundary, cpu_iaq, cpu_ia, cpu_pc, cpu_sp, cpu_a,
    input  sw_ready, ent_busy, ent_done, ent_pc, ent_sp, ent_a, ram_addr, ram_data, ram_wr
  );

  modport slave (
    input  sw_valid, sw_msg, cpu_boundary, cpu_iaq, cpu_ia, cpu_pc, cpu_sp, cpu_a,
    output sw_ready, ent_busy, ent_done, ent_pc, ent_sp, ent_a, ram_addr, ram_data, ram_wr
  );
endinterface

// File: rtl/dcpu_irq_unit.sv
// dcpu_irq_unit: interrupt queue and interrupt-entry sequencer for the dcpu16 core.
// Requests from N_SRC hardware sources and the software INT instruction are
// queued in a FIFO; at an instruction boundary the unit pops the head, pushes
// PC and A onto the stack through the shared RAM port and hands the core its
// new PC/SP/A.
//
// Ports:
//   CORE_CLK    : core clock; all state updates on the falling edge
//   RESET_N     : asynchronous active-low reset
//   src_req     : per-source request, held until acked
//   src_msg     : per-source message, slice i belongs to source i
//   src_ack     : one-hot, one cycle; request i was enqueued
//   q_count     : queue occupancy
//   q_overflow  : sticky; a request met a full queue
//   bus         : dcpu_irq_unit_if.slave (software INT, core state, entry handoff, RAM)
//
// Configuration:
//   DCPU_IRQ_RR_EN defined   : round-robin among hardware sources
//   DCPU_IRQ_RR_EN undefined : fixed priority, lowest index wins
module dcpu_irq_unit #(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned QUEUE_DEPTH = 256,
  parameter int unsigned MSG_W       = 16,
  localparam int unsigned PTR_W      = $clog2(QUEUE_DEPTH),
  localparam int unsigned CNT_W      = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                   CORE_CLK,
  input  logic                   RESET_N,
  input  logic [N_SRC-1:0]       src_req,
  input  logic [N_SRC*MSG_W-1:0] src_msg,
  output logic [N_SRC-1:0]       src_ack,
  output logic [CNT_W-1:0]       q_count,
  output logic                   q_overflow,
  dcpu_irq_unit_if.slave         bus
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [2:0] {StIdle, StPop, StWrPc, StWrA, StDone} state_e;

  state_e           r_state, w_state_next;
  logic             r_en;
  logic [MSG_W-1:0] r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [MSG_W-1:0] r_msg;

  logic             w_full, w_deq, w_enq_ok, w_sw_enq, w_hw_enq, w_enq, w_ovf_set;
  logic             w_sel_vld;
  logic [IDX_W-1:0] w_sel_idx;
  logic [MSG_W-1:0] w_hw_msg, w_wdata;
  logic [MSG_W-1:0] w_sp_m1, w_sp_m2;

  // ---------------------------------------------------------------------------
  // Hardware source arbitration
  // ---------------------------------------------------------------------------
`ifdef DCPU_IRQ_RR_EN
  logic [IDX_W-1:0] r_last;

  // Search starts one past the last acked source; reset value makes source 0 first.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      if (!w_sel_vld && src_req[(32'(r_last) + k) % N_SRC]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = IDX_W'((32'(r_last) + k) % N_SRC);
      end
    end
  end

  always_ff @(negedge CORE_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_last <= IDX_W'(N_SRC - 1);
    end else if (w_hw_enq) begin
      r_last <= w_sel_idx;
    end
  end
`else
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!w_sel_vld && src_req[k]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = IDX_W'(k);
      end
    end
  end
`endif

  assign w_hw_msg = src_msg[32'(w_sel_idx) * MSG_W +: MSG_W];

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  assign w_full = (r_count == CNT_W'(QUEUE_DEPTH));
  assign w_deq  = (r_state == StPop);

  // r_en keeps the queue closed (and all outputs low) until the first clock after reset.
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_enq_ok  = r_en && (!w_full || w_deq);
  assign w_sw_enq  = bus.sw_valid && w_enq_ok;
  assign w_hw_enq  = !bus.sw_valid && w_sel_vld && w_enq_ok;
  assign w_enq     = w_sw_enq || w_hw_enq;
  assign w_wdata   = bus.sw_valid ? bus.sw_msg : w_hw_msg;
  assign w_ovf_set = r_en && w_full && !w_deq && (bus.sw_valid || (|src_req));

  assign src_ack      = w_hw_enq ? (N_SRC'(1) << w_sel_idx) : '0;
  assign bus.sw_ready = w_enq_ok;
  assign q_count      = r_count;
  assign q_overflow   = r_overflow;

  always_ff @(negedge CORE_CLK) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(negedge CORE_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_en       <= 1'b0;
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_msg      <= '0;
    end else begin
      r_en    <= 1'b1;
      r_state <= w_state_next;
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_msg    <= r_mem[r_rd_ptr];
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Entry sequencer: outputs decoded from state so reset drops them at once
  // ---------------------------------------------------------------------------
  assign w_sp_m1 = bus.cpu_sp - MSG_W'(1);
  assign w_sp_m2 = bus.cpu_sp - MSG_W'(2);

  always_comb begin
    w_state_next = r_state;
    bus.ent_busy = 1'b0;
    bus.ent_done = 1'b0;
    bus.ent_pc   = '0;
    bus.ent_sp   = '0;
    bus.ent_a    = '0;
    bus.ram_addr = '0;
    bus.ram_data = '0;
    bus.ram_wr   = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.cpu_boundary && !bus.cpu_iaq && (r_count != '0)) begin
          w_state_next = StPop;
        end
      end
      StPop: begin
        bus.ent_busy = 1'b1;
        // IA==0 means interrupts are disabled: the message is dropped silently.
        w_state_next = (bus.cpu_ia == '0) ? StIdle : StWrPc;
      end
      StWrPc: begin
        bus.ent_busy = 1'b1;
        bus.ram_wr   = 1'b1;
        bus.ram_addr = 16'(w_sp_m1);
        bus.ram_data = bus.cpu_pc;
        w_state_next = StWrA;
      end
      StWrA: begin
        bus.ent_busy = 1'b1;
        bus.ram_wr   = 1'b1;
        bus.ram_addr = 16'(w_sp_m2);
        bus.ram_data = bus.cpu_a;
        w_state_next = StDone;
      end
      StDone: begin
        bus.ent_busy = 1'b1;
        bus.ent_done = 1'b1;
        bus.ent_pc   = bus.cpu_ia;
        bus.ent_sp   = w_sp_m2;
        bus.ent_a    = r_msg;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule
